// File: rtl/par_spi_tx.sv
// par_spi_tx: N-lane parallel SPI transmitter on the PicoRV32 native bus.
// Firmware pushes 32-bit words into a TX FIFO; each word is serialised as
// 32/LANES beats with a programmable dwell (div+1 cycles per phase).
module par_spi_tx #(
   parameter int LANES      = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sel,
   input  logic             mem_valid,
   input  logic [31:0]      mem_addr,
   input  logic [31:0]      mem_wdata,
   input  logic [3:0]       mem_wstrb,
   output logic             mem_ready,
   output logic [31:0]      mem_rdata,
   output logic [LANES-1:0] spi_data,
   output logic             spi_clk,
   output logic             spi_cs_n,
   output logic             spi_active,
   output logic             tx_irq
);

   localparam int BEATS = 32 / LANES;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, LOW, HIGH, GAP} state_t;

   // bus decode
   logic       take, wr, push_req, push_ok, pop;
   logic [1:0] reg_idx;
   logic       unused_addr;
   assign take        = mem_valid & sel & ~mem_ready;
   assign wr          = |mem_wstrb;
   assign reg_idx     = mem_addr[3:2];
   assign unused_addr = ^{mem_addr[31:4], mem_addr[1:0]};

   // control / status state
   logic [DIV_W-1:0] div_q;
   logic             en_q, msb_q, hold_q, irq_q, ovf;

   // FIFO
   logic [31:0]  fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   level;
   logic          full, empty;
   logic [31:0]   head;
   assign full     = (level == (AW+1)'(FIFO_DEPTH));
   assign empty    = (level == '0);
   assign head     = fifo_mem[rd_ptr];
   // capacity is judged on the level before any same-cycle pop
   assign push_req = take & wr & (reg_idx == 2'd0);
   assign push_ok  = push_req & ~full;

   // shifter FSM state
   state_t          state, state_n;
   logic [DIV_W-1:0] cnt, cnt_n;
   logic [BW-1:0]   beat, beat_n;
   logic [31:0]     sh, sh_n;
   logic            wmsb, wmsb_n;

   // register read mux
   logic [31:0] rd_val;
   always_comb begin
      rd_val = '0;
      case (reg_idx)
         2'd1: begin
            rd_val[DIV_W-1:0] = div_q;
            rd_val[16]        = en_q;
            rd_val[17]        = msb_q;
            rd_val[18]        = hold_q;
            rd_val[19]        = irq_q;
         end
         2'd2: begin
            rd_val[0]    = spi_active;
            rd_val[1]    = full;
            rd_val[2]    = empty;
            rd_val[3]    = ovf;
            rd_val[15:8] = 8'(level);
         end
         default: ;
      endcase
   end

   // bus acknowledge, read data and register writes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_ready <= 1'b0;
         mem_rdata <= '0;
         div_q     <= '0;
         en_q      <= 1'b0;
         msb_q     <= 1'b0;
         hold_q    <= 1'b0;
         irq_q     <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         mem_ready <= take;
         mem_rdata <= (take & ~wr) ? rd_val : '0;
         if (take & wr & (reg_idx == 2'd1)) begin
            div_q  <= mem_wdata[DIV_W-1:0];
            en_q   <= mem_wdata[16];
            msb_q  <= mem_wdata[17];
            hold_q <= mem_wdata[18];
            irq_q  <= mem_wdata[19];
         end
         if (take & wr & (reg_idx == 2'd2) & mem_wdata[3]) ovf <= 1'b0;
         if (push_req & full) ovf <= 1'b1;
      end
   end

   // FIFO storage needs no reset: pointers define validity
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr] <= mem_wdata;
   end

   // FIFO pointers and level
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: ;
         endcase
      end
   end

   // shifter FSM next state; every dwell reload samples div live
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      beat_n  = beat;
      sh_n    = sh;
      wmsb_n  = wmsb;
      pop     = 1'b0;
      case (state)
         IDLE: if (en_q & ~empty) begin
            pop     = 1'b1;
            sh_n    = head;
            wmsb_n  = msb_q;
            beat_n  = '0;
            cnt_n   = div_q;
            state_n = LOW;
         end
         LOW: if (cnt == '0) begin
            cnt_n   = div_q;
            state_n = HIGH;
         end else cnt_n = cnt - 1'b1;
         HIGH: if (cnt == '0) begin
            cnt_n = div_q;
            if (beat != BW'(BEATS-1)) begin
               beat_n  = beat + 1'b1;
               sh_n    = wmsb ? (sh << LANES) : (sh >> LANES);
               state_n = LOW;
            end else if (hold_q & en_q & ~empty) begin
               pop     = 1'b1;
               sh_n    = head;
               wmsb_n  = msb_q;
               beat_n  = '0;
               state_n = LOW;
            end else state_n = GAP;
         end else cnt_n = cnt - 1'b1;
         GAP: if (cnt == '0) state_n = IDLE;
              else cnt_n = cnt - 1'b1;
         default: state_n = IDLE;
      endcase
   end

   // shifter FSM registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         beat  <= '0;
         sh    <= '0;
         wmsb  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         beat  <= beat_n;
         sh    <= sh_n;
         wmsb  <= wmsb_n;
      end
   end

   // outputs decode straight from state so reset forces them at once
   logic framed;
   assign framed     = (state == LOW) | (state == HIGH);
   assign spi_active = (state != IDLE);
   assign spi_clk    = (state == HIGH);
   assign spi_cs_n   = ~framed;
   assign spi_data   = framed ? (wmsb ? sh[31 -: LANES] : sh[LANES-1:0]) : '0;
   assign tx_irq     = irq_q & empty & (state == IDLE);

endmodule

// File: doc/par_spi_tx.md
# par_spi_tx

Parametrised N-lane parallel SPI transmitter, memory-mapped on the PicoRV32 native memory bus. It is the successor to the fixed 8-lane output path hanging off the AES co-processor. Firmware pushes 32-bit words into a TX FIFO, and the block serialises each word over LANES data pins with a programmable clock divider, chip-select framing and an optional completion interrupt. It sits beside the block RAM in the SoC top and is selected by the top-level address decode.

## Interface
- LANES, 8, data pins per beat; one of 1, 2, 4, 8, 16, 32; beats per word = 32/LANES
- FIFO_DEPTH, 16, TX FIFO words; power of 2, 2..128
- DIV_W, 8, width of clock-divider field
- clk  in  1  system clock; the only clock
- reset  in  1  asynchronous, active-high reset
- sel  in  1  address decode hit for this block
- mem_valid  in  1  PicoRV32 bus request
- mem_addr  in  32  byte address; only [3:2] decoded
- mem_wdata  in  32  write data
- mem_wstrb  in  4  write strobes; nonzero = write, zero = read
- mem_ready  out  1  one-cycle access acknowledge
- mem_rdata  out  32  read data, valid while mem_ready=1
- spi_data  out  LANES  parallel data lanes
- spi_clk  out  1  data strobe; receiver samples on rising edge
- spi_cs_n  out  1  frame select, active low
- spi_active  out  1  FSM not IDLE
- tx_irq  out  1  level interrupt: CTRL.irq_en & FIFO empty & FSM IDLE

## Operation
- Register map (word offset):
  - 0x0 TXDATA: a write pushes mem_wdata. If the FIFO is full, the word is dropped and STATUS.ovf is set. Reads return 0.
  - 0x4 CTRL (R/W): [DIV_W-1:0] div, [16] enable, [17] msb_first, [18] cs_hold, [19] irq_en. Other bits read 0.
  - 0x8 STATUS: [0] busy (= spi_active), [1] full, [2] empty, [3] ovf (sticky; write 1 to clear), [15:8] FIFO level. Other bits are 0.
  - 0xC: reserved. Reads 0, writes ignored.
- Partial strobes to TXDATA or CTRL write the whole word; any nonzero strobe counts as a write.
- Push capacity:
  - A push is accepted iff level < FIFO_DEPTH in the access cycle.
  - A pop in the same cycle does not free space for that push.
  - A simultaneous push and pop leaves level unchanged.
- Beat order:
  - msb_first=0: the first beat drives word[LANES-1:0], then the next LANES bits upward.
  - msb_first=1: the first beat drives word[31:32-LANES], then downward.
- FSM states: IDLE, LOW, HIGH, GAP. Each LOW/HIGH/GAP dwell lasts div+1 clk cycles, counted by a DIV_W-bit down-counter.
  - IDLE: cs_n=1, spi_clk=0, spi_data=0. When enable and FIFO not empty: pop a word into the shift register, drive beat 0, set cs_n=0, go to LOW.
  - LOW: spi_clk=0, data stable. At dwell end go to HIGH.
  - HIGH: spi_clk=1. At dwell end:
    - beats remain: drive next beat, go to LOW.
    - last beat, cs_hold=1, enable=1, FIFO not empty: pop the next word, drive its beat 0, go to LOW with cs_n held low.
    - otherwise: go to GAP.
  - GAP: cs_n=1, spi_clk=0, spi_data=0. At dwell end go to IDLE.
- Clearing enable mid-word lets the current word finish, then GAP, then IDLE. Queued words remain in the FIFO.
- Writing CTRL.div mid-word takes effect at the next dwell reload.

## Timing
- Reset values (asynchronous):
  - spi_cs_n=1, spi_clk=0, spi_data=0, spi_active=0.
  - mem_ready=0, mem_rdata=0, tx_irq=0.
  - CTRL=0, FIFO empty, ovf=0, FSM IDLE.
  - STATUS reads 0x0000_0004.
- Bus handshake:
  - An access is taken in a cycle with mem_valid & sel & !mem_ready.
  - mem_ready is high exactly one cycle later, never two consecutive cycles.
  - Register and FIFO side-effects are visible the cycle mem_ready is high.
- IDLE to first cs_n low: 1 cycle after the FIFO becomes non-empty with enable=1.
- Word time: 2*(div+1)*(32/LANES) cycles. GAP adds div+1 cycles. IDLE adds 1 cycle per word.
- With cs_hold=1, back-to-back words have zero idle cycles and cs_n stays low.
- Reset asserted mid-word: outputs take reset values immediately and the FIFO contents are discarded.

## Test plan
- Reset: assert reset with traffic pending -> all outputs at reset values; STATUS read = 0x0000_0004; mem_ready pulses exactly 1 cycle after the request.
- LANES=8, div=0, enable=1, cs_hold=0; write 0xA1B2C3D4 -> cs_n low 8 cycles; spi_data 0xD4, 0xC3, 0xB2, 0xA1, one spi_clk rise per beat; then GAP 1 cycle; spi_active falls after 10 cycles; tx_irq=1 if irq_en=1.
- msb_first=1, cs_hold=1; queue 0xA1B2C3D4 and 0x01020304 -> beats A1, B2, C3, D4, 01, 02, 03, 04; cs_n low for 16 contiguous cycles.
- enable=0; write 17 words with FIFO_DEPTH=16 -> STATUS=0x0000_100A (level 16, full, ovf); write 0x8 to STATUS -> ovf=0; set enable -> 16 words transmitted in order.
- div=3, LANES=1 -> each spi_clk half-period is 4 cycles, 32 beats, word time 256 cycles; div rewritten mid-word applies at the next dwell.
- Reset pulsed at beat 2 of a word with 3 words queued -> cs_n=1 in the same cycle; after release FIFO empty and no further spi_clk edges.
